arb2x1_rr: RTL and testbench

- Two-input round-robin packet arbiter with a registered output stage.
- Merges two valid/ready source streams into one downstream stream.
- Data selection instantiates the team's mux2x1 (DW), with sel driven by the arbiter grant.
- Grant is locked for a whole packet, delimited by the last flag, so packets never interleave.

---
 rtl/arb2x1_rr.sv | 116 +++++++++++
 tb/tb_arb2x1_rr.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb2x1_rr.sv
// Two-input round-robin packet arbiter with a registered output stage.
// Grant is held for a whole packet (delimited by last) so packets never interleave.

module mux2x1 #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          sel,
    output logic [DW-1:0] y
);

    assign y = sel ? b : a;

endmodule

module arb2x1_rr #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in0_valid,
    input  logic [DW-1:0] in0_data,
    input  logic          in0_last,
    output logic          in0_ready,
    input  logic          in1_valid,
    input  logic [DW-1:0] in1_data,
    input  logic          in1_last,
    output logic          in1_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          out_src,
    input  logic          out_ready
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOCK0 = 2'd1;
    localparam logic [1:0] LOCK1 = 2'd2;

    logic [1:0]    state;
    logic          last_grant;
    logic          can_load;
    logic          gnt_valid;
    logic          gnt;
    logic          gnt_last;
    logic [DW-1:0] mux_out;

    assign can_load = !out_valid || out_ready;

    // Readies are also held low while rst is asserted, so nothing is
    // accepted while the output register is being cleared.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs (no latch).
        gnt_valid = 1'b0;
        gnt       = 1'b0;
        if (can_load && !rst) begin
            case (state)
                IDLE: begin
                    if (in0_valid && in1_valid) begin
                        gnt_valid = 1'b1;
                        gnt       = !last_grant;
                    end else if (in0_valid) begin
                        gnt_valid = 1'b1;
                    end else if (in1_valid) begin
                        gnt_valid = 1'b1;
                        gnt       = 1'b1;
                    end
                end
                LOCK0: gnt_valid = in0_valid;
                LOCK1: begin
                    gnt_valid = in1_valid;
                    gnt       = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in0_ready = gnt_valid && !gnt;
    assign in1_ready = gnt_valid && gnt;
    assign gnt_last  = gnt ? in1_last : in0_last;

    mux2x1 #(.DW(DW)) u_mux (
        .a   (in0_data),
        .b   (in1_data),
        .sel (gnt),
        .y   (mux_out)
    );

    // NOTE: non-blocking assignments for all registered state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            out_src    <= 1'b0;
            state      <= IDLE;
            last_grant <= 1'b1;
        end else if (can_load) begin
            out_valid <= gnt_valid;
            if (gnt_valid) begin
                out_data <= mux_out;
                out_last <= gnt_last;
                out_src  <= gnt;
                if (gnt_last) begin
                    state      <= IDLE;
                    last_grant <= gnt;
                end else begin
                    state <= gnt ? LOCK1 : LOCK0;
                end
            end
        end
    end

endmodule

// File: tb/tb_arb2x1_rr.sv
// Self-checking bench for arb2x1_rr: directed scenarios plus a randomized run
// compared against a behavioural packet-arbitration model.

module tb_arb2x1_rr;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in0_valid, in0_last, in0_ready;
    logic          in1_valid, in1_last, in1_ready;
    logic [DW-1:0] in0_data, in1_data;
    logic          out_valid, out_last, out_src, out_ready;
    logic [DW-1:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    arb2x1_rr #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_last  (in0_last),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_last  (in1_last),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        in0_valid = 1'b0; in0_data = '0; in0_last = 1'b0;
        in1_valid = 1'b0; in1_data = '0; in1_last = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        quiet();
        out_ready = 1'b1;
        in0_valid = 1'b1; in0_data = 8'h99; in0_last = 1'b1;
        tick();
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_async_valid: got %b want 0", out_valid);
        end
        n_checks++;
        if (in0_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b want 0", in0_ready);
        end
        tick();
        rst = 1'b0;
        n_checks++;
        if (out_data !== 8'h00 || out_src !== 1'b0 || out_last !== 1'b0) begin
            n_fail++; $display("FAIL reset_regs: got data=%h src=%b last=%b want 00/0/0", out_data, out_src, out_last);
        end
        in0_data = 8'h11; in0_last = 1'b1; out_ready = 1'b1;
        #1;
        n_checks++;
        if (in0_ready !== 1'b1) begin
            n_fail++; $display("FAIL first_ready: got %b want 1", in0_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h11 || out_src !== 1'b0) begin
            n_fail++; $display("FAIL first_beat: got v=%b d=%h s=%b want 1/11/0", out_valid, out_data, out_src);
        end
        quiet();
        tick();
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_data [4];
        exp_data = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
        quiet();
        pulse_reset();
        out_ready = 1'b1;
        in0_valid = 1'b1; in0_data = 8'hA0; in0_last = 1'b1;
        in1_valid = 1'b1; in1_data = 8'hB0; in1_last = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++;
            if (in0_ready !== (k % 2 == 0) || in1_ready !== (k % 2 == 1)) begin
                n_fail++; $display("FAIL rr_ready[%0d]: got %b%b want %b%b", k, in1_ready, in0_ready, k % 2 == 1, k % 2 == 0);
            end
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_data[k] || out_src !== 1'(k % 2)) begin
                n_fail++; $display("FAIL rr_beat[%0d]: got d=%h s=%b want %h/%0d", k, out_data, out_src, exp_data[k], k % 2);
            end
            if (k % 2 == 0) in0_data = in0_data + 8'h01;
            else            in1_data = in1_data + 8'h01;
        end
        quiet();
        tick();
    endtask

    task automatic test_packet_lock();
        logic [7:0] exp_data [4];
        exp_data = '{8'h01, 8'h02, 8'h03, 8'h77};
        quiet();
        out_ready = 1'b1;
        in1_valid = 1'b1; in1_data = 8'h77; in1_last = 1'b1;
        in0_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                in0_data = exp_data[k];
                in0_last = (k == 2);
            end else begin
                in0_valid = 1'b0;
            end
            #1;
            n_checks++;
            if (in1_ready !== (k == 3) || in0_ready !== (k < 3)) begin
                n_fail++; $display("FAIL lock_ready[%0d]: got in0=%b in1=%b", k, in0_ready, in1_ready);
            end
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_data[k] || out_src !== (k == 3) || out_last !== (k >= 2)) begin
                n_fail++; $display("FAIL lock_beat[%0d]: got d=%h s=%b l=%b want %h", k, out_data, out_src, out_last, exp_data[k]);
            end
        end
        quiet();
        tick();
    endtask

    task automatic test_back_to_back();
        quiet();
        out_ready = 1'b1;
        in0_valid = 1'b1; in0_data = 8'h55; in0_last = 1'b1;
        tick();
        quiet();
        out_ready = 1'b0;
        in1_valid = 1'b1; in1_data = 8'h66; in1_last = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++;
            if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_ready[%0d]: got in0=%b in1=%b want 0/0", k, in0_ready, in1_ready);
            end
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h55) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got v=%b d=%h want 1/55", k, out_valid, out_data);
            end
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in1_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release_ready: got %b want 1", in1_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h66 || out_src !== 1'b1) begin
            n_fail++; $display("FAIL bp_release_beat: got v=%b d=%h s=%b want 1/66/1", out_valid, out_data, out_src);
        end
        quiet();
        tick();
    endtask

    task automatic test_lock_gap();
        quiet();
        out_ready = 1'b1;
        in1_valid = 1'b1; in1_data = 8'h10; in1_last = 1'b0;
        #1;
        n_checks++;
        if (in1_ready !== 1'b1) begin
            n_fail++; $display("FAIL gap_start_ready: got %b want 1", in1_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h10 || out_src !== 1'b1) begin
            n_fail++; $display("FAIL gap_start_beat: got v=%b d=%h s=%b want 1/10/1", out_valid, out_data, out_src);
        end
        in1_valid = 1'b0;
        in0_valid = 1'b1; in0_data = 8'h22; in0_last = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (in0_ready !== 1'b0) begin
                n_fail++; $display("FAIL gap_in0_ready[%0d]: got %b want 0", k, in0_ready);
            end
            tick();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL gap_bubble[%0d]: got %b want 0", k, out_valid);
            end
        end
        in1_valid = 1'b1; in1_data = 8'h11; in1_last = 1'b1;
        #1;
        n_checks++;
        if (in0_ready !== 1'b0 || in1_ready !== 1'b1) begin
            n_fail++; $display("FAIL gap_end_ready: got in0=%b in1=%b want 0/1", in0_ready, in1_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h11 || out_src !== 1'b1 || out_last !== 1'b1) begin
            n_fail++; $display("FAIL gap_end_beat: got d=%h s=%b l=%b want 11/1/1", out_data, out_src, out_last);
        end
        in1_valid = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h22 || out_src !== 1'b0) begin
            n_fail++; $display("FAIL gap_in0_beat: got v=%b d=%h s=%b want 1/22/0", out_valid, out_data, out_src);
        end
        quiet();
        tick();
    endtask

    task automatic test_reset_mid_packet();
        quiet();
        out_ready = 1'b1;
        in0_valid = 1'b1; in0_data = 8'h31; in0_last = 1'b0;
        tick();
        quiet();
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_valid: got %b want 0", out_valid);
        end
        tick();
        rst = 1'b0;
        // A lock surviving reset would block a lone in1 beat here.
        in1_valid = 1'b1; in1_data = 8'h51; in1_last = 1'b1;
        #1;
        n_checks++;
        if (in1_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst_unlock: got %b want 1", in1_ready);
        end
        tick();
        quiet();
        in0_valid = 1'b1; in0_data = 8'h33; in0_last = 1'b1;
        tick();
        in0_data = 8'h34; in0_last = 1'b0;
        tick();
        quiet();
        pulse_reset();
        in0_valid = 1'b1; in0_data = 8'h41; in0_last = 1'b1;
        in1_valid = 1'b1; in1_data = 8'h52; in1_last = 1'b1;
        #1;
        n_checks++;
        if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
            n_fail++; $display("FAIL midrst_rr: got in0=%b in1=%b want 1/0", in0_ready, in1_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h41 || out_src !== 1'b0) begin
            n_fail++; $display("FAIL midrst_beat: got v=%b d=%h s=%b want 1/41/0", out_valid, out_data, out_src);
        end
        quiet();
        tick();
    endtask

    // Reference model: a locked source (or none) owns the output until it
    // sends a last beat; with no owner the source that did not finish the
    // previous packet wins ties.
    task automatic test_random();
        bit       vv [2];
        bit [7:0] dd [2];
        bit       ll [2];
        int       m_lock = -1;
        int       m_prev = 1;
        int       m_win;
        bit       m_valid = 1'b0;
        bit [7:0] m_data  = 8'h00;
        bit       m_last  = 1'b0;
        bit       m_src   = 1'b0;
        bit       m_free;
        quiet();
        pulse_reset();
        for (int c = 0; c < 300; c++) begin
            for (int s = 0; s < 2; s++) begin
                vv[s] = ($urandom_range(0, 3) != 0);
                dd[s] = 8'($urandom);
                ll[s] = ($urandom_range(0, 2) == 0);
            end
            in0_valid = vv[0]; in0_data = dd[0]; in0_last = ll[0];
            in1_valid = vv[1]; in1_data = dd[1]; in1_last = ll[1];
            out_ready = ($urandom_range(0, 3) != 0);

            m_free = !m_valid || out_ready;
            m_win  = -1;
            if (m_free) begin
                if (m_lock >= 0)       m_win = vv[m_lock] ? m_lock : -1;
                else if (vv[0] && vv[1]) m_win = 1 - m_prev;
                else if (vv[0])        m_win = 0;
                else if (vv[1])        m_win = 1;
            end
            #1;
            n_checks++;
            if (in0_ready !== (m_win == 0) || in1_ready !== (m_win == 1)) begin
                n_fail++; $display("FAIL rand_ready[%0d]: got in0=%b in1=%b want %b/%b", c, in0_ready, in1_ready, m_win == 0, m_win == 1);
            end
            if (m_free) begin
                if (m_win >= 0) begin
                    m_valid = 1'b1;
                    m_data  = dd[m_win];
                    m_last  = ll[m_win];
                    m_src   = 1'(m_win);
                    if (ll[m_win]) begin
                        m_lock = -1;
                        m_prev = m_win;
                    end else begin
                        m_lock = m_win;
                    end
                end else begin
                    m_valid = 1'b0;
                end
            end
            tick();
            n_checks++;
            if (out_valid !== m_valid || out_data !== m_data || out_last !== m_last || out_src !== m_src) begin
                n_fail++;
                $display("FAIL rand_out[%0d]: got v=%b d=%h l=%b s=%b want %b/%h/%b/%b",
                         c, out_valid, out_data, out_last, out_src, m_valid, m_data, m_last, m_src);
            end
        end
        quiet();
        tick();
    endtask

    initial begin
        quiet();
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_back_to_back();
        test_lock_gap();
        test_reset_mid_packet();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
